// File: rtl/sim_mem_io_if.sv
// CPU memory bus plus the output-port byte stream of sim_mem_io.
// The master side is the cpu/host; the slave side is the memory.
interface sim_mem_io_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_wr;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W/8-1:0] wr_be;
  logic [DATA_W-1:0]   rd_data;
  logic [7:0]          out_data;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output mem_addr, mem_wr, wr_data, wr_be, out_ready,
    input  rd_data, out_data, out_valid
  );

  modport slave (
    input  mem_addr, mem_wr, wr_data, wr_be, out_ready,
    output rd_data, out_data, out_valid
  );
endinterface

// File: rtl/sim_mem_io.sv
// Simulation/FPGA memory with byte-enable writes, a FIFO-backed output port,
// a halt register and a cycle counter with timeout.
module sim_mem_io #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16,
  parameter int OUT_ADDR   = 1,
  parameter int HALT_ADDR  = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  sim_mem_io_if.slave bus,
  output logic        out_overflow,
  output logic        halted,
  output logic        timed_out,
  output logic [31:0] cycle_count
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int          PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [ADDR_W-1:0] OUT_A    = ADDR_W'(OUT_ADDR);
  localparam logic [ADDR_W-1:0] HALT_A   = ADDR_W'(HALT_ADDR);
  localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [31:0]       TO_LAST  = (TIMEOUT == 0) ? '0 : 32'(TIMEOUT - 1);

  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("sim_mem_io: DATA_W must be a multiple of 8");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sim_mem_io: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  logic [DATA_W-1:0] mem  [2**ADDR_W];
  logic [7:0]        fifo [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic wr_en, push_req, push_ok, pop, full, halt_wr, counting, not_empty;

  assign wr_en     = bus.mem_wr && !halted;
  assign push_req  = wr_en && (bus.mem_addr == OUT_A) && bus.wr_be[0];
  assign not_empty = (count != '0);
  assign pop       = not_empty && bus.out_ready;
  assign full      = (count == FULL_CNT);
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign push_ok   = push_req && (!full || pop);
  assign halt_wr   = wr_en && (bus.mem_addr == HALT_A);
  assign counting  = !halted && !timed_out;

  assign bus.out_valid = not_empty;
  assign bus.out_data  = not_empty ? fifo[rd_ptr] : '0;

  // Array is deliberately not reset so contents survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (bus.wr_be[i]) mem[bus.mem_addr][8*i +: 8] <= bus.wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo[wr_ptr] <= bus.wr_data[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rd_data  <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      out_overflow <= 1'b0;
      halted       <= 1'b0;
      timed_out    <= 1'b0;
      cycle_count  <= '0;
    end else begin
      if (!bus.mem_wr) bus.rd_data <= mem[bus.mem_addr];

      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
      if (push_req && full && !pop) out_overflow <= 1'b1;

      if (halt_wr) halted <= 1'b1;

      if (counting) begin
        if (cycle_count != '1) cycle_count <= cycle_count + 32'd1;
        if (TIMEOUT != 0 && cycle_count == TO_LAST) timed_out <= 1'b1;
      end
    end
  end

endmodule

// File: doc/sim_mem_io.md
Name: sim_mem_io

Overview:
- Parametrised, synthesizable successor to the single-port 1K x 16 simulation memory on the cpu bus.
- Adds byte-enable writes and a memory-mapped output port backed by a FIFO with valid/ready drain.
- Adds a halt register and a cycle counter with a timeout flag, so bench and FPGA top both detect program end without $finish.
- Sits between cpu (mem_addr/mem_wr/wr_data/rd_data) and the host/UART side.

Parameters:
ADDR_W, 10, memory address width; array has 2**ADDR_W words
DATA_W, 16, word width; must be a multiple of 8
OUT_ADDR, 1, word address of output-port register
HALT_ADDR, 2, word address of halt register
FIFO_DEPTH, 8, output FIFO entries; power of 2, >= 2
TIMEOUT, 1000, cycle limit; 0 disables timeout

Ports:
clk  input  1  clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
mem_addr  input  ADDR_W  word address from cpu
mem_wr  input  1  1 = write cycle, 0 = read cycle
wr_data  input  DATA_W  write data
wr_be  input  DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i]
rd_data  output  DATA_W  registered read data
out_data  output  8  FIFO head byte (first-word fall-through)
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts head this cycle
out_overflow  output  1  sticky: a push was dropped
halted  output  1  sticky: HALT_ADDR was written
timed_out  output  1  sticky: TIMEOUT reached
cycle_count  output  32  cycles since reset

Behaviour:
- Reset (rst_n=0, async): rd_data=0, FIFO empty (out_valid=0, out_data=0), out_overflow=0, halted=0, timed_out=0, cycle_count=0. Memory array is not reset; contents survive reset mid-run.
- Read: mem_wr=0 -> rd_data <= mem[mem_addr] at next edge (1-cycle latency). When mem_wr=1, rd_data holds its previous value.
- Write: mem_wr=1 and halted=0 -> each byte lane with wr_be[i]=1 is written; other lanes are unchanged. Write-through applies to OUT_ADDR and HALT_ADDR (the array is also updated).
- Halted: all array writes are suppressed and no further FIFO pushes occur. Reads are still serviced and the FIFO still drains.
- Push: mem_wr=1, mem_addr==OUT_ADDR, wr_be[0]=1, halted=0 -> push wr_data[7:0]. wr_be[0]=0 -> no push.
- Pop: out_valid && out_ready. The next entry (or empty) is visible the cycle after the pop.
- Full, push without pop: byte dropped, contents unchanged, out_overflow <= 1.
- Full, push with simultaneous pop: both succeed, count unchanged, no overflow.
- Empty, push with out_ready=1: no pop that cycle (out_valid was 0). Byte appears with out_valid=1 next cycle.
- FIFO pointers wrap modulo FIFO_DEPTH. Count is held in log2(FIFO_DEPTH)+1 bits to distinguish full from empty.
- Halt: write to HALT_ADDR (any wr_be) -> halted=1 from next cycle. A write to OUT_ADDR in the same cycle is irrelevant since the addresses differ.
- cycle_count: +1 every cycle while halted=0 and timed_out=0; frozen otherwise. Saturates at 2**32-1.
- Timeout: TIMEOUT!=0 and cycle_count==TIMEOUT-1 while counting -> timed_out=1 next cycle, and cycle_count stops at TIMEOUT.
- If halt and timeout trigger in the same cycle, both flags set.
- TIMEOUT=0: timed_out never sets.
- Elaboration error if DATA_W%8!=0 or FIFO_DEPTH is not a power of 2 >= 2.

Test Plan:
- Reset/read latency: preload mem[0x100]=0x1234; release rst_n, drive addr 0x100, mem_wr=0 -> rd_data=0x1234 exactly one edge later; all flags 0, out_valid=0.
- Byte enables: write 0xAABB with wr_be=2'b01 to addr 5 holding 0x1122, then read -> 0x11BB. Then wr_be=2'b10 with 0xCC00 -> 0xCCBB.
- Output FIFO: out_ready=0, write 0x41..0x48 to OUT_ADDR (8 pushes) -> full, out_data=0x41. 9th write 0x49 -> out_overflow=1. Then out_ready=1 -> drains 0x41..0x48 in order, out_valid falls after the 8th pop.
- Full push+pop: fill 8 entries, then push 0x50 with out_ready=1 in the same cycle -> no overflow. Draining yields 0x42..0x48 followed by 0x50.
- Halt: write 0x0001 to HALT_ADDR at cycle N -> halted=1 at N+1 and cycle_count frozen. A subsequent write of 0xFFFF to addr 7 is ignored (read returns old value); an OUT_ADDR write is not pushed.
- Timeout and async reset: TIMEOUT=20, no halt -> timed_out=1 when cycle_count=20. Assert rst_n=0 mid-cycle -> all outputs 0 immediately; memory contents preserved on re-read.
